// File: rtl/cursor_trail_renderer.sv
// Renders a blinking cursor plus a circular trail of marked positions as RGB565
// pixel colour for the OLED driver's scan index, one registered cycle later.
module cursor_trail_renderer #(
    parameter int          TRAIL_DEPTH   = 16,
    parameter int          BLINK_DIV     = 3125000,
    parameter logic [15:0] CURSOR_COLOUR = 16'hFFFF,
    parameter logic [15:0] TRAIL_COLOUR  = 16'h07E0,
    parameter logic [15:0] BG_COLOUR     = 16'h0000
) (
    input  logic        CLOCK,
    input  logic        RESETN,
    input  logic        freeze,
    input  logic [7:0]  cursor_x,
    input  logic [7:0]  cursor_y,
    input  logic        mark,
    input  logic        clear,
    input  logic [12:0] pixel_index,
    output logic [15:0] oled_data,
    output logic [5:0]  trail_count,
    output logic        trail_full
);

    localparam int              PW          = $clog2(TRAIL_DEPTH);
    localparam int              BW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0]   BLINK_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [5:0]      DEPTH_COUNT = 6'(TRAIL_DEPTH);

    logic [6:0]    trail_x [TRAIL_DEPTH];
    logic [5:0]    trail_y [TRAIL_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [6:0]    last_x;
    logic [5:0]    last_y;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          mark_prev;

    logic [12:0]   pix_col;
    logic [12:0]   pix_row;
    logic          pix_valid;
    logic          cursor_hit;
    logic          trail_hit;
    logic          pos_valid;
    logic          is_dup;
    logic          accept;

    assign trail_full = (trail_count == DEPTH_COUNT);

    assign pos_valid = (cursor_x <= 8'd95) && (cursor_y <= 8'd63);
    assign is_dup    = ({1'b0, last_x} == cursor_x) && ({2'b0, last_y} == cursor_y);
    assign accept    = RESETN && mark && !mark_prev && !freeze && !clear && pos_valid &&
                       ((trail_count == 6'd0) || !is_dup);

    assign pix_col   = pixel_index % 13'd96;
    assign pix_row   = pixel_index / 13'd96;
    // Gate is needed: an off-range cursor_y could otherwise match rows past 63.
    assign pix_valid = (pixel_index <= 13'd6143);

    assign cursor_hit = (blink_on || freeze) &&
                        (pix_col == {5'b0, cursor_x}) && (pix_row == {5'b0, cursor_y});

    always_comb begin
        trail_hit = 1'b0;
        for (int unsigned i = 0; i < TRAIL_DEPTH; i++) begin
            if ((6'(i) < trail_count) &&
                (pix_col == {6'b0, trail_x[i]}) && (pix_row == {7'b0, trail_y[i]}))
                trail_hit = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN)
            oled_data <= BG_COLOUR;
        else if (!pix_valid)
            oled_data <= BG_COLOUR;
        else if (cursor_hit)
            oled_data <= CURSOR_COLOUR;
        else if (trail_hit)
            oled_data <= TRAIL_COLOUR;
        else
            oled_data <= BG_COLOUR;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            mark_prev   <= 1'b0;
            trail_count <= '0;
            wr_ptr      <= '0;
            last_x      <= '0;
            last_y      <= '0;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            mark_prev <= mark;

            if (clear) begin
                trail_count <= '0;
                wr_ptr      <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                last_x <= cursor_x[6:0];
                last_y <= cursor_y[5:0];
                if (trail_count != DEPTH_COUNT)
                    trail_count <= trail_count + 6'd1;
            end
        end
    end

    // Storage needs no reset: entries at or beyond trail_count are never rendered.
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            trail_x[wr_ptr] <= cursor_x[6:0];
            trail_y[wr_ptr] <= cursor_y[5:0];
        end
    end

endmodule

// File: tb/tb_cursor_trail_renderer.sv
// Bench for cursor_trail_renderer: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_cursor_trail_renderer;

    localparam int          DEPTH  = 16;
    localparam int          BDIV   = 4;
    localparam logic [15:0] CUR_C  = 16'hFFFF;
    localparam logic [15:0] TRL_C  = 16'h07E0;
    localparam logic [15:0] BG_C   = 16'h0000;

    logic        CLOCK;
    logic        RESETN;
    logic        freeze;
    logic [7:0]  cursor_x;
    logic [7:0]  cursor_y;
    logic        mark;
    logic        clear;
    logic [12:0] pixel_index;
    logic [15:0] oled_data;
    logic [5:0]  trail_count;
    logic        trail_full;

    int n_checks;
    int n_fail;

    // reference model state
    int unsigned cyc;
    int          qx[$];
    int          qy[$];
    bit          mprev_m;

    cursor_trail_renderer #(
        .TRAIL_DEPTH  (DEPTH),
        .BLINK_DIV    (BDIV),
        .CURSOR_COLOUR(CUR_C),
        .TRAIL_COLOUR (TRL_C),
        .BG_COLOUR    (BG_C)
    ) dut (
        .CLOCK      (CLOCK),
        .RESETN     (RESETN),
        .freeze     (freeze),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .mark       (mark),
        .clear      (clear),
        .pixel_index(pixel_index),
        .oled_data  (oled_data),
        .trail_count(trail_count),
        .trail_full (trail_full)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_colour(input int pi, input int cx, input int cy,
                                                 input bit frz);
        int  px;
        int  py;
        bit  vis;
        if (pi > 6143) return BG_C;
        px  = pi % 96;
        py  = pi / 96;
        vis = (((cyc / BDIV) % 2) == 0) || frz;
        if (vis && px == cx && py == cy) return CUR_C;
        foreach (qx[k])
            if (qx[k] == px && qy[k] == py) return TRL_C;
        return BG_C;
    endfunction

    task automatic step();
        logic [15:0] exp_oled;
        bit          edge_m;
        int          cx;
        int          cy;
        cx = int'(cursor_x);
        cy = int'(cursor_y);
        exp_oled = RESETN ? model_colour(int'(pixel_index), cx, cy, freeze) : BG_C;
        @(posedge CLOCK);
        if (!RESETN) begin
            cyc = 0;
            qx.delete();
            qy.delete();
            mprev_m = 1'b0;
        end else begin
            cyc++;
            edge_m  = mark && !mprev_m;
            mprev_m = mark;
            if (clear) begin
                qx.delete();
                qy.delete();
            end else if (edge_m && !freeze && cx < 96 && cy < 64 &&
                         (qx.size() == 0 || qx[$] != cx || qy[$] != cy)) begin
                qx.push_back(cx);
                qy.push_back(cy);
                if (qx.size() > DEPTH) begin
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                end
            end
        end
        #1;
        check("oled_data", 32'(oled_data), 32'(exp_oled));
        check("trail_count", 32'(trail_count), 32'(qx.size()));
        check("trail_full", 32'(trail_full), 32'(qx.size() == DEPTH));
    endtask

    task automatic set_cursor(input int x, input int y);
        cursor_x = 8'(x);
        cursor_y = 8'(y);
    endtask

    task automatic press();
        mark = 1'b1;
        step();
        mark = 1'b0;
        step();
    endtask

    initial begin
        int sel;
        int k;
        int pi;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        mprev_m  = 1'b0;
        RESETN = 1'b0; freeze = 1'b0; mark = 1'b0; clear = 1'b0;
        cursor_x = 8'd0; cursor_y = 8'd0; pixel_index = 13'd0;

        // reset
        step();
        step();
        check("rst_oled", 32'(oled_data), 32'h0000);
        check("rst_count", 32'(trail_count), 32'd0);

        // decode and latency
        RESETN = 1'b1;
        set_cursor(5, 2);
        pixel_index = 13'd197;
        step();
        check("decode_cursor", 32'(oled_data), 32'hFFFF);
        pixel_index = 13'd198;
        step();
        check("decode_bg", 32'(oled_data), 32'h0000);

        // held mark gives one append; duplicate dropped
        set_cursor(10, 10);
        mark = 1'b1;
        repeat (20) step();
        mark = 1'b0;
        step();
        check("held_mark_count", 32'(trail_count), 32'd1);
        set_cursor(11, 10);
        pixel_index = 13'd970;
        step();
        check("trail_pixel", 32'(oled_data), 32'h07E0);
        press();
        check("repress_count", 32'(trail_count), 32'd2);
        press();
        check("dup_count", 32'(trail_count), 32'd2);

        // wrap at depth
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            set_cursor(i, 0);
            press();
        end
        check("wrap_full", 32'(trail_full), 32'd1);
        set_cursor(50, 50);
        pixel_index = 13'd0;
        step();
        check("wrap_oldest_gone", 32'(oled_data), 32'h0000);
        pixel_index = 13'd16;
        step();
        check("wrap_newest", 32'(oled_data), 32'h07E0);

        // blink then freeze
        pixel_index = 13'(50 * 96 + 50);
        repeat (16) step();
        freeze = 1'b1;
        repeat (8) step();
        press();
        freeze = 1'b0;
        step();

        // clear beats mark; invalid cursor; out-of-range pixel
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cursor(20 + i, 30);
            press();
        end
        set_cursor(40, 30);
        mark  = 1'b1;
        clear = 1'b1;
        step();
        mark  = 1'b0;
        clear = 1'b0;
        step();
        check("clear_beats_mark", 32'(trail_count), 32'd0);
        set_cursor(96, 0);
        press();
        set_cursor(0, 64);
        press();
        pixel_index = 13'd6144;
        step();
        pixel_index = 13'd6200;
        step();

        // reset with mark in flight
        set_cursor(7, 7);
        press();
        set_cursor(8, 7);
        mark   = 1'b1;
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        mark   = 1'b0;
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 8)
                set_cursor($urandom_range(0, 99), $urandom_range(0, 67));
            mark   = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 19) == 0);
            clear  = ($urandom_range(0, 199) == 0);
            RESETN = ($urandom_range(0, 499) != 0);
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                pi = int'(cursor_y) * 96 + int'(cursor_x);
            end else if (sel == 1 && qx.size() > 0) begin
                k  = $urandom_range(0, qx.size() - 1);
                pi = qy[k] * 96 + qx[k];
            end else begin
                pi = $urandom_range(0, 8191);
            end
            pixel_index = 13'(pi);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_trail_renderer.md
Name: cursor_trail_renderer

Overview:
- Consumer end of the cursor-position interface: takes the cursor X/Y produced by the button-driven cursor-location block and turns it into OLED pixel colour.
- Runs in the same clock domain as the OLED driver. Answers that driver's pixel_index requests with a registered 16-bit RGB565 colour.
- Draws a blinking cursor plus a circular buffer of up to TRAIL_DEPTH previously marked positions, over a background.

Parameters:
- TRAIL_DEPTH, 16, number of stored trail points (power of 2, 2..32)
- BLINK_DIV, 3125000, clock cycles per blink half-period (0.5 s at 6.25 MHz)
- CURSOR_COLOUR, 16'hFFFF, RGB565 colour of the cursor pixel
- TRAIL_COLOUR, 16'h07E0, RGB565 colour of the trail pixels
- BG_COLOUR, 16'h0000, RGB565 background colour

Ports:
- CLOCK  in  1  system clock (OLED pixel clock domain)
- RESETN  in  1  synchronous active-low reset
- freeze  in  1  level; when 1, marking is inhibited and the cursor is shown solid
- cursor_x  in  8  cursor column, valid 0..95
- cursor_y  in  8  cursor row, valid 0..63
- mark  in  1  level (button); each rising edge appends the current cursor to the trail
- clear  in  1  level; while 1, the trail is emptied
- pixel_index  in  13  OLED scan index, 0..6143
- oled_data  out  16  RGB565 colour for pixel_index
- trail_count  out  6  number of valid trail entries, 0..TRAIL_DEPTH
- trail_full  out  1  high when trail_count == TRAIL_DEPTH

Behaviour:
- All state changes on posedge CLOCK. RESETN is sampled synchronously and is active-low.
- Reset values: oled_data = BG_COLOUR, trail_count = 0, trail_full = 0, write pointer = 0, blink_on = 1, blink counter = 0, mark_prev = 0. Trail storage contents are don't-care after reset; entries at or beyond trail_count are never rendered.
- Pixel decode: px = pixel_index mod 96, py = pixel_index div 96.
  - Use exact integer arithmetic on 13 bits.
  - pixel_index > 6143 gives BG_COLOUR.
- Colour priority, highest first:
  1. cursor: (px,py) == (cursor_x,cursor_y) and the cursor is visible.
  2. trail: (px,py) matches any valid trail entry.
  3. background.
- Cursor is visible when blink_on = 1 or freeze = 1.
- Latency: oled_data is registered, exactly 1 cycle after pixel_index. It reflects cursor, trail and blink state sampled in the same edge as pixel_index.
- Blink:
  - Counter runs 0..BLINK_DIV-1.
  - On the cycle the counter equals BLINK_DIV-1, it wraps to 0 and blink_on toggles.
  - While freeze = 1 the counter keeps running; only visibility is forced on.
- Mark edge detect:
  - mark_prev is registered each cycle.
  - An append is requested when mark = 1 and mark_prev = 0.
  - A held button gives exactly one append.
- Append is accepted only if all of the following hold; otherwise the edge is dropped and no state changes:
  - freeze = 0 and clear = 0.
  - cursor_x ≤ 95 and cursor_y ≤ 63.
  - The position differs from the most recently written entry, or trail_count = 0.
- Accepted append:
  - entry[wr_ptr] takes (cursor_x, cursor_y); wr_ptr increments modulo TRAIL_DEPTH.
  - trail_count increments, saturating at TRAIL_DEPTH.
  - When full, the append overwrites the oldest entry (circular). trail_full stays 1.
- Clear: while clear = 1, trail_count = 0 and wr_ptr = 0 on every cycle. Clear beats mark on the same cycle.
- Visibility of new state: trail_count and trail_full update 1 cycle after the mark edge is sampled. A new entry appears in oled_data on the first pixel_index sampled after that update.
- Reset mid-operation: all state returns to reset values on the next edge; an in-flight mark edge is discarded.

Test Plan:
- Reset: RESETN = 0 for 2 cycles, pixel_index = 0 → oled_data = 16'h0000, trail_count = 0, trail_full = 0.
- Decode and latency: cursor = (5,2), BLINK_DIV = 4, blink_on = 1, pixel_index = 197 → oled_data = 16'hFFFF the next cycle. pixel_index = 198 → 16'h0000.
- Mark: cursor (10,10), mark held high 20 cycles → trail_count = 1. Move cursor to (11,10), pixel_index = 970 → 16'h07E0. Re-press at (11,10) twice → count = 2, then stays 2 (duplicate dropped).
- Wrap: TRAIL_DEPTH = 16, mark 17 distinct points (0,0),(1,0)..(16,0) → trail_count = 16, trail_full = 1. Pixel (0,0) → BG, pixel (16,0) → TRAIL_COLOUR.
- Blink and freeze: BLINK_DIV = 4, cursor pixel shows 16'hFFFF for 4 cycles, then 16'h0000 for 4 cycles, repeating. freeze = 1 → constant 16'hFFFF, and a mark edge leaves trail_count unchanged.
- Clear and boundaries: mark and clear rise in the same cycle with count = 5 → count = 0. Cursor (96,0) plus mark → count unchanged. pixel_index = 6200 → BG_COLOUR.
